l2_event_tx: RTL

//  Transmit side of the L2 event interface. Buffers address-events (AER) from the upstream layer or host.

---
 rtl/l2_event_tx_pkg.sv | 14 +
 rtl/l2_event_tx_if.sv | 8 +
 rtl/l2_event_tx_sync_fifo.sv | 44 ++++
 rtl/l2_event_tx.sv | 80 ++++++++
 4 files changed

// File: rtl/l2_event_tx_pkg.sv
// l2_event_tx_pkg: shared constants, FSM states and helpers for the L2 event transmitter
package l2_event_tx_pkg;
   localparam int P_S = 10;
   localparam int P_N = 10;
   typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_GAP} state_t;
   function automatic int clog2(input int v);
      int r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
      return r;
   endfunction
   function automatic logic addr_legal(input int addr, input int s);
      return addr >= 1 && addr <= s;
   endfunction
endpackage

// File: rtl/l2_event_tx_if.sv
// l2_event_tx_if: AER valid/ready handshake between upstream producer and the transmitter
interface l2_event_tx_if #(parameter int p_addr_w = 4);
   logic                i_valid;
   logic [p_addr_w-1:0] i_addr;
   logic                o_ready;
   modport master (output i_valid, i_addr, input o_ready);
   modport slave (input i_valid, i_addr, output o_ready);
endinterface

// File: rtl/l2_event_tx_sync_fifo.sv
// sync_fifo: synchronous FIFO with extra-MSB pointers and a registered read-data port
module sync_fifo #(
   parameter int p_width = 4,
   parameter int p_depth = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_push,
   input  logic [p_width-1:0]         i_data,
   input  logic                       i_pop,
   output logic [p_width-1:0]         o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(p_depth):0]   o_level
);
   localparam int aw = $clog2(p_depth);
   logic [p_width-1:0] mem_q [p_depth];
   logic [p_width-1:0] mem_d [p_depth];
   logic [aw:0]        wr_q, wr_d, rd_q, rd_d;
   logic [p_width-1:0] data_q, data_d;
   always_comb begin
      mem_d = mem_q;
      wr_d = wr_q + (aw+1)'(i_push);
      rd_d = rd_q + (aw+1)'(i_pop);
      data_d = i_pop ? mem_q[rd_q[aw-1:0]] : data_q;
      if (i_push) mem_d[wr_q[aw-1:0]] = i_data;
   end
   always_ff @(posedge i_clk) begin
      mem_q <= mem_d;
      if (i_rst) begin
         wr_q <= '0;
         rd_q <= '0;
         data_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         data_q <= data_d;
      end
   end
   assign o_level = wr_q - rd_q;
   assign o_full = o_level == (aw+1)'(p_depth);
   assign o_empty = o_level == '0;
   assign o_data = data_q;
endmodule

// File: rtl/l2_event_tx.sv
// l2_event_tx: buffers AER events and replays them as gap-spaced one-hot pulses to L2
module l2_event_tx import l2_event_tx_pkg::*; #(
   parameter int p_s = P_S,
   parameter int p_addr_w = 4,
   parameter int p_depth = 8,
   parameter int p_gap = 4,
   parameter int p_cnt_w = 16
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   l2_event_tx_if.slave                bus,
   output logic [p_s:1]                o_event,
   output logic                        o_busy,
   output logic [clog2(p_depth):0]     o_level,
   output logic [p_cnt_w-1:0]          o_drop_cnt
);
   localparam int tw = clog2(p_gap + 1);
   logic                ready, full, empty, legal, accept, push, pop;
   logic [p_addr_w-1:0] head;
   state_t              state_q, state_d;
   logic [tw-1:0]       timer_q, timer_d;
   logic [p_s:1]        event_q, event_d;
   logic [p_cnt_w-1:0]  drop_q, drop_d;
   sync_fifo #(.p_width(p_addr_w), .p_depth(p_depth)) u_fifo (
      .i_clk(i_clk), .i_rst(i_rst), .i_push(push), .i_data(bus.i_addr), .i_pop(pop),
      .o_data(head), .o_full(full), .o_empty(empty), .o_level(o_level)
   );
   assign ready = ~full;
   assign bus.o_ready = ready;
   assign legal = addr_legal(int'(bus.i_addr), p_s);
   assign accept = bus.i_valid & ready;
   assign push = accept & legal;
   assign drop_d = (accept & ~legal & ~&drop_q) ? drop_q + 1'b1 : drop_q;
   // GAP leaves one cycle early so the next EMIT lands exactly p_gap after the last pulse
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      event_d = '0;
      pop = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            pop = ~empty;
            state_d = empty ? ST_IDLE : ST_EMIT;
         end
         ST_EMIT: begin
            event_d = p_s'(1) << (head - 1'b1);
            timer_d = tw'(p_gap - 1);
            if (p_gap > 1) state_d = ST_GAP;
            else begin
               pop = ~empty;
               state_d = empty ? ST_IDLE : ST_EMIT;
            end
         end
         ST_GAP: begin
            timer_d = timer_q - 1'b1;
            if (timer_q <= tw'(1)) begin
               pop = ~empty;
               state_d = empty ? ST_IDLE : ST_EMIT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         event_q <= '0;
         drop_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         event_q <= event_d;
         drop_q <= drop_d;
      end
   end
   assign o_event = event_q;
   assign o_drop_cnt = drop_q;
   assign o_busy = (o_level != '0) | (state_q != ST_IDLE);
endmodule
